alu_seq: RTL

Parametrised, handshaked successor to the processor's 8-bit combinational ALU. Accepts one operation per transaction on a valid/ready input port and returns a registered result plus a 4-bit status flag word on a valid/ready output port. ADD, SUB and the logic ops complete in one cycle; MUL runs as an iterative shift-add over WIDTH cycles. It sits between the register-file read stage and write-back.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode_e : operation codes carried on the 3-bit opcode field
//   - FLAG_*   : bit positions inside the 4-bit flag word {V,N,C,Z}
//   - ST_*     : controller state encodings
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } opcode_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle of the sequential ALU.
//   in_valid/in_ready/in1/in2/opcode    : operation input port
//   out_valid/out_ready/data_out/flag_out : result output port
//   busy                                : multiplier iterating
// Modports: master = producer/consumer side, slave = ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [3:0]       flag_out;
  logic             busy;

  modport master (
    output in_valid, in1, in2, opcode, out_ready,
    input  in_ready, out_valid, data_out, flag_out, busy
  );

  modport slave (
    input  in_valid, in1, in2, opcode, out_ready,
    output in_ready, out_valid, data_out, flag_out, busy
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a run)
//   start      : latch a/b, clear accumulator and bit counter
//   a, b       : multiplicand, multiplier
//   done       : high in the cycle the final bit is being consumed
//   product    : 2*WIDTH-bit product, valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      cnt;
  logic               run;

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // Product is presented combinationally on the last step so the parent can
  // register it in the same edge that retires the final multiplier bit.
  assign done    = run && (cnt == CW'(WIDTH - 1));
  assign product = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ADD/SUB/logic ops, iterative MUL.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave (operation in, registered result + flags out,
//                busy while multiplying)
// Flags are {V,N,C,Z}; PASS re-emits the previous result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  logic [1:0]         state;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                            input logic c, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    return f;
  endfunction

  // Returns {flags, result} for every non-MUL opcode.
  function automatic logic [WIDTH+3:0] alu_eval(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] prev_d,
    input logic [3:0]       prev_f
  );
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      default: return {prev_f, prev_d};
    endcase
    return {pack_flags(v, r[WIDTH-1], c, r == '0), r};
  endfunction

  assign is_mul       = (bus.opcode == OP_MUL);
  assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.in1),
    .b       (bus.in2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bus.data_out <= '0;
      bus.flag_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL;
            end else begin
              {bus.flag_out, bus.data_out} <= alu_eval(bus.opcode, bus.in1, bus.in2,
                                                       bus.data_out, bus.flag_out);
              state <= ST_DONE;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            bus.data_out <= mul_product[WIDTH-1:0];
            bus.flag_out <= pack_flags(1'b0, mul_product[WIDTH-1],
                                       |mul_product[2*WIDTH-1:WIDTH],
                                       mul_product[WIDTH-1:0] == '0);
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
